dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters: port A (core load/store
//   stage, normal priority winner) and port B (debug/loader port). Grants one access per
//   cycle, drives the data memory, routes the 1-cycle-latency read data back to its owner,
//   bounds B starvation and rejects misaligned/illegal accesses before they reach memory.
// PARAMETERS
//   MAX_WAIT  4  consecutive lost cycles after which a requesting B wins over A (>=1)
//   CNT_W     3  width of the B wait counter; must hold MAX_WAIT
// PORTS
//   clk          in   1   clock, all state on posedge
//   rst_n        in   1   asynchronous active-low reset
//   a_req        in   1   A request; addr/size/we/wdata/unsigned held stable until a_gnt
//   a_we         in   1   A: 1 = store, 0 = load
//   a_unsigned   in   1   A: zero-extend load (1) or sign-extend (0)
//   a_size       in   3   A: transfer bytes, legal values 1, 2, 4
//   a_addr       in   32  A: byte address
//   a_wdata      in   32  A: store data, low-aligned
//   a_gnt        out  1   A request accepted this cycle (combinational)
//   a_rvalid     out  1   A response valid (load data or error), cycle after grant
//   a_err        out  1   A response is a misalignment/size error; valid with a_rvalid
//   a_rdata      out  32  A load data; 0 when a_err
//   b_*          --   --  identical set for port B (b_req, b_we, ... b_rdata)
//   mem_write    out  1   to data memory: write enable
//   mem_read     out  1   to data memory: read enable
//   is_unsigned  out  1   to data memory: extension mode of granted access
//   xfer_size    out  3   to data memory: size of granted access
//   address      out  32  to data memory: byte address
//   w_data       out  32  to data memory: store data
//   r_data       in   32  from data memory: read data, valid 1 cycle after address
// BEHAVIOUR
//   - Reset (async, rst_n low): a/b_rvalid=0, a/b_err=0, a/b_rdata=0, wait_cnt=0,
//     rd_owner=NONE; memory-side outputs are combinational and read 0 with no grant.
//   - Arbitration (combinational, per cycle): winner = B if b_req && (!a_req ||
//     wait_cnt==MAX_WAIT); else A if a_req; else none. Exactly one gnt max per cycle.
//   - wait_cnt: +1 (saturating at MAX_WAIT) when b_req && !b_gnt; cleared on b_gnt
//     or when b_req is low.
//   - Legal check on winner: size in {1,2,4}; size 2 needs addr[0]==0; size 4 needs
//     addr[1:0]==0. Illegal -> gnt still asserted, mem_write=mem_read=0, error response.
//   - Legal granted store: mem_write=1, fields muxed from winner; no response issued.
//   - Legal granted load: mem_read=1; rd_owner<=winner. Next cycle owner's rvalid=1,
//     rdata=r_data, err=0. Back-to-back loads from either port every cycle are allowed.
//   - Error response: next cycle owner's rvalid=1, err=1, rdata=0.
//   - Responses are registered pulses lasting exactly one cycle; no response for stores.
//   - No grant: all memory outputs 0 (address=0, mem_read=mem_write=0).
//   - Reset mid-operation: a load granted in the cycle reset asserts gets no rvalid.
//   - Requester may drop req without gnt; wait_cnt clears, nothing issued.
// TESTING
//   1. A load size 4 addr 8, mem word 8 = 0x1234_5678 -> a_gnt same cycle, mem_read=1,
//      next cycle a_rvalid=1, a_rdata=0x1234_5678, a_err=0.
//   2. a_req and b_req held high every cycle -> a_gnt cycles 1-4, b_gnt cycle 5,
//      wait_cnt returns to 0, then A wins again (MAX_WAIT=4).
//   3. A load addr 0 then B load addr 4 on consecutive cycles -> a_rvalid cycle 2,
//      b_rvalid cycle 3, each with its own word; no cross-routing.
//   4. A size 2 addr 1 -> a_gnt=1, mem_read=mem_write=0; next cycle a_rvalid=1,
//      a_err=1, a_rdata=0. Same for size 3 addr 0.
//   5. B store size 1 addr 5 data 0x80, then B load size 1 addr 5 signed -> 0xFFFF_FF80;
//      unsigned -> 0x0000_0080.
//   6. A load granted, rst_n low next cycle -> a_rvalid stays 0; after release first
//      A load completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: A wins by default, B gets a
// turn after MAX_WAIT lost cycles; misaligned/illegal accesses are answered with an error.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_unsigned,
    input  logic [2:0]  a_size,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic        a_err,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_unsigned,
    input  logic [2:0]  b_size,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic        b_err,
    output logic [31:0] b_rdata,

    output logic        mem_write,
    output logic        mem_read,
    output logic        is_unsigned,
    output logic [2:0]  xfer_size,
    output logic [31:0] address,
    output logic [31:0] w_data,
    input  logic [31:0] r_data
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } owner_e;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    owner_e           rd_owner_q, rd_owner_d;
    logic             a_rvalid_q, a_rvalid_d;
    logic             b_rvalid_q, b_rvalid_d;
    logic             a_err_q, a_err_d;
    logic             b_err_q, b_err_d;

    logic             a_win, b_win, any_win, legal;
    logic             sel_we, sel_uns;
    logic [2:0]       sel_size;
    logic [31:0]      sel_addr, sel_wdata;

    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            3'd1:    is_legal = 1'b1;
            3'd2:    is_legal = ~lo[0];
            3'd4:    is_legal = (lo == 2'b00);
            default: is_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        b_win   = b_req && (!a_req || (wait_cnt_q == WAIT_LIMIT));
        a_win   = a_req && !b_win;
        any_win = a_win || b_win;

        if (b_win) begin
            sel_we    = b_we;
            sel_uns   = b_unsigned;
            sel_size  = b_size;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end else begin
            sel_we    = a_we;
            sel_uns   = a_unsigned;
            sel_size  = a_size;
            sel_addr  = a_addr;
            sel_wdata = a_wdata;
        end

        legal = any_win && is_legal(sel_size, sel_addr[1:0]);
    end

    assign a_gnt = a_win;
    assign b_gnt = b_win;

    // Memory side is fully zeroed unless a legal access is being issued this cycle.
    always_comb begin
        mem_write   = legal && sel_we;
        mem_read    = legal && !sel_we;
        is_unsigned = legal ? sel_uns   : 1'b0;
        xfer_size   = legal ? sel_size  : '0;
        address     = legal ? sel_addr  : '0;
        w_data      = legal ? sel_wdata : '0;
    end

    always_comb begin
        wait_cnt_d = '0;
        if (b_req && !b_win) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        rd_owner_d = OWN_NONE;
        if (mem_read) begin
            rd_owner_d = b_win ? OWN_B : OWN_A;
        end

        // Every grant except a legal store produces a response next cycle.
        a_rvalid_d = a_win && !(legal && sel_we);
        b_rvalid_d = b_win && !(legal && sel_we);
        a_err_d    = a_win && !legal;
        b_err_d    = b_win && !legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            rd_owner_q <= OWN_NONE;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
        end
    end

    // Read data arrives from memory in the response cycle, so it is steered, not stored.
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_err    = a_err_q;
    assign b_err    = b_err_q;
    assign a_rdata  = (rd_owner_q == OWN_A) ? r_data : '0;
    assign b_rdata  = (rd_owner_q == OWN_B) ? r_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory responder, a per-cycle reference model
// checked at every falling edge, directed scenarios and a randomized phase.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_req, a_we, a_unsigned, b_req, b_we, b_unsigned;
    logic [2:0]  a_size, b_size;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_write, mem_read, is_unsigned;
    logic [2:0]  xfer_size;
    logic [31:0] address, w_data;
    logic [31:0] r_data = '0;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_unsigned(a_unsigned), .a_size(a_size),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_unsigned(b_unsigned), .b_size(b_size),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .b_err(b_err), .b_rdata(b_rdata),
        .mem_write(mem_write), .mem_read(mem_read), .is_unsigned(is_unsigned),
        .xfer_size(xfer_size), .address(address), .w_data(w_data), .r_data(r_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] size,
                                           input logic uns);
        case (size)
            3'd1:    return uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            3'd2:    return uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] raw_env(input logic [7:0] a);
        return {env_mem[a + 8'd3], env_mem[a + 8'd2], env_mem[a + 8'd1], env_mem[a]};
    endfunction

    function automatic logic [31:0] raw_ref(input logic [7:0] a);
        return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    task automatic put_word(input logic [7:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            env_mem[a + 8'(i)] = v[8*i +: 8];
            ref_mem[a + 8'(i)] = v[8*i +: 8];
        end
    endtask

    // Memory responder: acts on whatever the DUT presents, data returned one cycle later.
    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < int'(xfer_size); i++)
                env_mem[address[7:0] + 8'(i)] = w_data[8*i +: 8];
        end
        if (mem_read)
            r_data <= extend(raw_env(address[7:0]), xfer_size, is_unsigned);
    end

    // Reference model: lost-cycle count for B, pending response, shadow memory.
    int          lost = 0;
    bit          pend_v = 0, pend_err = 0, pend_b = 0;
    logic [31:0] pend_data = '0;

    always @(negedge clk) begin : model
        bit          bw, aw, ok, s_we, s_uns, exa, exb;
        logic [2:0]  s_size;
        logic [31:0] s_addr, s_wdata;
        if (!rst_n) begin
            chk("reset a_rvalid", a_rvalid, 0);
            chk("reset b_rvalid", b_rvalid, 0);
            lost   = 0;
            pend_v = 0;
        end else begin
            exa = pend_v && !pend_b;
            exb = pend_v && pend_b;
            chk("a_rvalid", a_rvalid, exa);
            chk("a_err", a_err, exa && pend_err);
            chk("a_rdata", a_rdata, exa ? pend_data : 32'h0);
            chk("b_rvalid", b_rvalid, exb);
            chk("b_err", b_err, exb && pend_err);
            chk("b_rdata", b_rdata, exb ? pend_data : 32'h0);

            bw = b_req && (!a_req || lost >= MAX_WAIT);
            aw = a_req && !bw;
            chk("a_gnt", a_gnt, aw);
            chk("b_gnt", b_gnt, bw);
            s_we    = bw ? b_we : a_we;
            s_uns   = bw ? b_unsigned : a_unsigned;
            s_size  = bw ? b_size : a_size;
            s_addr  = bw ? b_addr : a_addr;
            s_wdata = bw ? b_wdata : a_wdata;
            ok = (aw || bw) && ((s_size == 1) || (s_size == 2 && s_addr % 2 == 0) ||
                                (s_size == 4 && s_addr % 4 == 0));
            chk("mem_read", mem_read, ok && !s_we);
            chk("mem_write", mem_write, ok && s_we);
            if (ok) begin
                chk("address", address, s_addr);
                chk("xfer_size", xfer_size, s_size);
                chk("is_unsigned", is_unsigned, s_uns);
                if (s_we) chk("w_data", w_data, s_wdata);
            end else begin
                chk("idle address", address, 0);
            end

            lost = (b_req && !bw) ? ((lost < MAX_WAIT) ? lost + 1 : lost) : 0;
            pend_v    = (aw || bw) && !(ok && s_we);
            pend_err  = !ok;
            pend_b    = bw;
            pend_data = (ok && !s_we) ? extend(raw_ref(s_addr[7:0]), s_size, s_uns) : 32'h0;
            if (ok && s_we) begin
                for (int i = 0; i < int'(s_size); i++)
                    ref_mem[s_addr[7:0] + 8'(i)] = s_wdata[8*i +: 8];
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #2;
    endtask

    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, we, uns, input logic [2:0] size,
                         input logic [31:0] addr, wdata);
        a_req = req; a_we = we; a_unsigned = uns; a_size = size; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic set_b(input logic req, we, uns, input logic [2:0] size,
                         input logic [31:0] addr, wdata);
        b_req = req; b_we = we; b_unsigned = uns; b_size = size; b_addr = addr; b_wdata = wdata;
    endtask

    task automatic rand_fields(output logic we, uns, output logic [2:0] size,
                               output logic [31:0] addr, wdata);
        int r;
        r    = $urandom_range(0, 7);
        size = (r < 3) ? 3'd1 : (r < 5) ? 3'd2 : (r < 7) ? 3'd4 : 3'($urandom_range(0, 7));
        addr = $urandom_range(0, 255);
        if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
        we    = 1'($urandom_range(0, 1));
        uns   = 1'($urandom_range(0, 1));
        wdata = $urandom;
    endtask

    initial begin
        bit          ga, gb;
        logic        we, uns;
        logic [2:0]  sz;
        logic [31:0] ad, wd;

        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        put_word(8'd0, 32'hA5A5_0001);
        put_word(8'd4, 32'h5A5A_0002);
        put_word(8'd8, 32'h1234_5678);
        set_a(0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        mid();
        chk("reset mem_read", mem_read, 0);
        chk("reset address", address, 0);
        chk("reset a_rdata", a_rdata, 0);

        // Plain A word load.
        next_cycle(); set_a(1, 0, 0, 3'd4, 32'd8, 0);
        mid(); chk("t1 a_gnt", a_gnt, 1); chk("t1 mem_read", mem_read, 1); chk("t1 address", address, 8);
        next_cycle(); set_a(0, 0, 0, 0, 0, 0);
        mid(); chk("t1 a_rvalid", a_rvalid, 1); chk("t1 a_rdata", a_rdata, 32'h1234_5678);
        chk("t1 a_err", a_err, 0);

        // Both ports requesting continuously: B only every fifth cycle.
        next_cycle(); set_a(1, 0, 0, 3'd4, 32'd16, 0); set_b(1, 0, 0, 3'd4, 32'd20, 0);
        for (int c = 1; c <= 6; c++) begin
            mid(); chk("t2 a_gnt", a_gnt, c != 5); chk("t2 b_gnt", b_gnt, c == 5);
            next_cycle();
        end

        // A then B loads back to back, responses routed to their owners.
        set_b(0, 0, 0, 0, 0, 0); set_a(1, 0, 0, 3'd4, 32'd0, 0);
        mid();
        next_cycle(); set_a(0, 0, 0, 0, 0, 0); set_b(1, 0, 0, 3'd4, 32'd4, 0);
        mid(); chk("t3 a_rvalid", a_rvalid, 1); chk("t3 a_rdata", a_rdata, 32'hA5A5_0001);
        chk("t3 b_rvalid early", b_rvalid, 0);
        next_cycle(); set_b(0, 0, 0, 0, 0, 0);
        mid(); chk("t3 b_rvalid", b_rvalid, 1); chk("t3 b_rdata", b_rdata, 32'h5A5A_0002);
        chk("t3 a_rvalid late", a_rvalid, 0);

        // Misaligned halfword, then illegal size 3.
        next_cycle(); set_a(1, 0, 0, 3'd2, 32'd1, 0);
        mid(); chk("t4 a_gnt", a_gnt, 1); chk("t4 mem_read", mem_read, 0); chk("t4 mem_write", mem_write, 0);
        next_cycle(); set_a(1, 0, 0, 3'd3, 32'd0, 0);
        mid(); chk("t4 a_err", a_err, 1); chk("t4 a_rdata", a_rdata, 0); chk("t4 sz3 mem_read", mem_read, 0);
        next_cycle(); set_a(0, 0, 0, 0, 0, 0);
        mid(); chk("t4 sz3 a_rvalid", a_rvalid, 1); chk("t4 sz3 a_err", a_err, 1);

        // Byte store from B, then signed and unsigned byte loads of it.
        next_cycle(); set_b(1, 1, 0, 3'd1, 32'd5, 32'h80);
        mid(); chk("t5 b_gnt", b_gnt, 1); chk("t5 mem_write", mem_write, 1);
        next_cycle(); set_b(1, 0, 0, 3'd1, 32'd5, 0);
        mid(); chk("t5 store no rvalid", b_rvalid, 0);
        next_cycle(); set_b(1, 0, 1, 3'd1, 32'd5, 0);
        mid(); chk("t5 signed b_rdata", b_rdata, 32'hFFFF_FF80);
        next_cycle(); set_b(0, 0, 0, 0, 0, 0);
        mid(); chk("t5 unsigned b_rdata", b_rdata, 32'h0000_0080);

        // Load granted while reset asserts: no response; next load after release completes.
        next_cycle(); set_a(1, 0, 0, 3'd4, 32'd8, 0); rst_n = 1'b0;
        mid();
        next_cycle(); set_a(0, 0, 0, 0, 0, 0); rst_n = 1'b1;
        mid(); chk("t6 a_rvalid after reset", a_rvalid, 0);
        next_cycle(); set_a(1, 0, 0, 3'd4, 32'd8, 0);
        mid(); chk("t6 a_gnt", a_gnt, 1);
        next_cycle(); set_a(0, 0, 0, 0, 0, 0);
        mid(); chk("t6 a_rvalid", a_rvalid, 1); chk("t6 a_rdata", a_rdata, 32'h1234_5678);

        // Randomized traffic: requests held until granted, occasionally withdrawn.
        ga = 1'b1;
        gb = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            if (!a_req || ga) begin
                rand_fields(we, uns, sz, ad, wd);
                set_a(($urandom_range(0, 3) != 0), we, uns, sz, ad, wd);
            end else if ($urandom_range(0, 15) == 0) begin
                a_req = 1'b0;
            end
            if (!b_req || gb) begin
                rand_fields(we, uns, sz, ad, wd);
                set_b(($urandom_range(0, 3) != 0), we, uns, sz, ad, wd);
            end else if ($urandom_range(0, 15) == 0) begin
                b_req = 1'b0;
            end
            mid();
            ga = a_gnt;
            gb = b_gnt;
        end

        next_cycle(); set_a(0, 0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0, 0);
        mid();
        mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
